axi_fb_slave: RTL and testbench

AXI_FB_SLAVE -- requirements
Module: axi_fb_slave

---
 rtl/axi_fb_pkg.sv | 17 +
 rtl/fb_ram.sv | 42 ++++
 rtl/axi_fb_slave.sv | 190 +++++++++++++++++++
 tb/tb_axi_fb_slave.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_fb_pkg.sv
// Shared types and constants for the AXI frame-buffer slave.
// Holds the FSM state encoding, AXI response codes and the only accepted beat size.
// Imported by axi_fb_slave.
package axi_fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B = 3'h2;

endpackage

// File: rtl/fb_ram.sv
// Frame-buffer pixel store: simple dual-port, 24-bit words, one enable per colour byte.
// Latency: read data registered, valid the cycle after re; read-first on address collision.
// Backpressure: none; rdata holds its last value while re is low.
// Ports: clk/rst, write port (we, be, waddr, wdata), read port (re, raddr, rdata).
module fb_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [2:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [23:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [23:0]   rdata
);

    logic [23:0] mem [DEPTH];

    // Pixel contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < 32'(DEPTH))) begin
            for (int i = 0; i < 3; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Non-blocking write above means a same-edge read sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (32'(raddr) < 32'(DEPTH)) ? mem[raddr] : 24'h000000;
        end
    end

endmodule

// File: rtl/axi_fb_slave.sv
// AXI4 write-only slave storing single-beat 32-bit RGB888 pixel writes into a frame buffer.
// Latency: 2 cycles from the later of the AW/W handshakes to bvalid; scan-out read 1 cycle.
// Backpressure: awready/wready drop once each channel is captured, until bready completes the B handshake.
// Ports: s_axi_aclk/s_axi_areset, AXI AW/W/B channels, rd_en_i/rd_addr_i/rd_data_o scan-out,
//        wr_cnt_o (OKAY write count), frame_done_o (pulse on write to last pixel).
// Build option: define AXI_FB_WSTRB_EN to honour wstrb[2:0] as B/G/R byte enables.
module axi_fb_slave
    import axi_fb_pkg::*;
#(
    parameter logic [31:0] C_S_AXI_BASE_ADDR = 32'h40000000,
    parameter int          FB_WIDTH          = 1920,
    parameter int          FB_HEIGHT         = 1080,
    localparam int         FB_DEPTH          = FB_WIDTH * FB_HEIGHT
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic [31:0]                 s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [31:0]                 s_axi_wdata,
    input  logic [3:0]                  s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic                        rd_en_i,
    input  logic [$clog2(FB_DEPTH)-1:0] rd_addr_i,
    output logic [23:0]                 rd_data_o,
    output logic [31:0]                 wr_cnt_o,
    output logic                        frame_done_o
);

    localparam int IDX_W = $clog2(FB_DEPTH);

    state_t      state, state_nxt;
    logic        aw_cap, w_cap;
    logic [31:0] awaddr_q;
    logic [7:0]  awlen_q;
    logic [2:0]  awsize_q;
    logic [23:0] wdata_q;
    logic [2:0]  wstrb_q;
    logic        wlast_q;
    logic        aw_hs, w_hs, have_aw, have_w, len_nz, last_now;
    logic [31:0] offset;
    logic        legal;
    logic [IDX_W-1:0] idx;
    logic        mem_we;
    logic [2:0]  mem_be;
    logic        unused_ok;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;

    // The decision to leave IDLE is made in the handshake cycle itself, merging
    // registered and incoming channel data; this keeps the 2-cycle B latency.
    assign have_aw  = aw_cap | aw_hs;
    assign have_w   = w_cap | w_hs;
    assign len_nz   = aw_cap ? (awlen_q != 8'd0) : (s_axi_awlen != 8'd0);
    assign last_now = w_cap ? wlast_q : s_axi_wlast;

    assign offset = awaddr_q - C_S_AXI_BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];
    assign legal  = (awlen_q == 8'd0) && (awsize_q == AXI_SIZE_4B) && (awaddr_q[1:0] == 2'b00)
                 && (awaddr_q >= C_S_AXI_BASE_ADDR) && ((offset >> 2) < 32'(FB_DEPTH));

`ifdef AXI_FB_WSTRB_EN
    assign mem_be    = wstrb_q;
    assign unused_ok = ^{s_axi_awburst, s_axi_wdata[31:24], s_axi_wstrb[3]};
`else
    assign mem_be    = 3'b111;
    assign unused_ok = ^{s_axi_awburst, s_axi_wdata[31:24], s_axi_wstrb[3], wstrb_q};
`endif

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        mem_we        = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated by reset so both readies sit low while reset is held.
                s_axi_awready = ~aw_cap & ~s_axi_areset;
                s_axi_wready  = ~w_cap & ~s_axi_areset;
                if (have_aw && have_w) begin
                    state_nxt = (len_nz && !last_now) ? DRAIN : COMMIT;
                end
            end
            DRAIN: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) begin
                    state_nxt = RESP;
                end
            end
            COMMIT: begin
                mem_we    = legal & ~s_axi_areset;
                state_nxt = RESP;
            end
            RESP: begin
                if (s_axi_bready) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            aw_cap       <= 1'b0;
            w_cap        <= 1'b0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            awsize_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wlast_q      <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            wr_cnt_o     <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (aw_hs) begin
                aw_cap   <= 1'b1;
                awaddr_q <= s_axi_awaddr;
                awlen_q  <= s_axi_awlen;
                awsize_q <= s_axi_awsize;
            end
            // Only the first beat is kept; burst tail beats in DRAIN are discarded.
            if (w_hs && state == IDLE) begin
                w_cap   <= 1'b1;
                wdata_q <= s_axi_wdata[23:0];
                wstrb_q <= s_axi_wstrb[2:0];
                wlast_q <= s_axi_wlast;
            end
            unique case (state)
                DRAIN: begin
                    if (s_axi_wvalid && s_axi_wlast) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= RESP_SLVERR;
                    end
                end
                COMMIT: begin
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= legal ? RESP_OKAY : RESP_SLVERR;
                    if (legal) begin
                        wr_cnt_o     <= wr_cnt_o + 32'd1;
                        frame_done_o <= ((offset >> 2) == 32'(FB_DEPTH - 1));
                    end
                end
                RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        aw_cap       <= 1'b0;
                        w_cap        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    fb_ram #(
        .DEPTH (FB_DEPTH),
        .AW    (IDX_W)
    ) u_fb_ram (
        .clk   (s_axi_aclk),
        .rst   (s_axi_areset),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (idx),
        .wdata (wdata_q),
        .re    (rd_en_i),
        .raddr (rd_addr_i),
        .rdata (rd_data_o)
    );

endmodule

// File: tb/tb_axi_fb_slave.sv
`timescale 1ns/1ps
module tb_axi_fb_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic        rd_en_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic [23:0] rd_data_o;
    logic [31:0] wr_cnt_o;
    logic        frame_done_o;

    always #5 clk = ~clk;

    axi_fb_slave #(
        .C_S_AXI_BASE_ADDR (BASE),
        .FB_WIDTH          (8),
        .FB_HEIGHT         (4)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .wr_cnt_o      (wr_cnt_o),
        .frame_done_o  (frame_done_o)
    );

    typedef struct packed {
        logic [1:0] resp;
        logic       frame;
    } bexp_t;

    int          vectors = 0;
    int          miscompares = 0;
    bexp_t       bq[$];
    logic [23:0] rq[$];
    logic        prev_bvalid = 1'b0;
    logic        rd_fire = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: B channel and read data are checked against queued expectations.
    always @(posedge clk) rd_fire <= rd_en_i;

    always @(negedge clk) begin
        if (!rst) begin
            if (s_axi_bvalid) begin
                if (bq.size() == 0) begin
                    chk("unexpected_bvalid", 32'(s_axi_bvalid), 32'd0);
                end else begin
                    chk("bresp", 32'(s_axi_bresp), 32'(bq[0].resp));
                    if (!prev_bvalid) chk("frame_done_at_b", 32'(frame_done_o), 32'(bq[0].frame));
                    else if (frame_done_o) chk("frame_done_extra", 32'(frame_done_o), 32'd0);
                    if (s_axi_bready) void'(bq.pop_front());
                end
            end else if (frame_done_o) begin
                chk("frame_done_without_b", 32'(frame_done_o), 32'd0);
            end
            if (rd_fire) begin
                if (rq.size() == 0) chk("unexpected_read", 32'(rd_fire), 32'd0);
                else chk("rd_data", 32'(rd_data_o), 32'(rq.pop_front()));
            end
        end
        prev_bvalid = s_axi_bvalid;
    end

    task automatic push_b(input logic [1:0] resp, input logic frame);
        bexp_t e;
        e.resp  = resp;
        e.frame = frame;
        bq.push_back(e);
    endtask

    // Generic write: AW presented after aw_dly cycles, W beats from cycle 0.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [7:0] len, input int nbeats, input logic [2:0] size,
                             input int aw_dly, input logic [1:0] resp, input logic frame);
        bit aw_left = 1'b1;
        int beat = 0;
        int cyc = 0;
        bit hs_aw, hs_w;
        push_b(resp, frame);
        while ((aw_left || beat < nbeats) && cyc < 100) begin
            s_axi_awvalid = aw_left && (cyc >= aw_dly);
            s_axi_awaddr  = addr;
            s_axi_awlen   = len;
            s_axi_awsize  = size;
            s_axi_awburst = 2'b01;
            s_axi_wvalid  = (beat < nbeats);
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_wlast   = (beat == nbeats - 1);
            @(negedge clk);
            chk("no_early_b", 32'(s_axi_bvalid), 32'd0);
            hs_aw = s_axi_awvalid && s_axi_awready;
            hs_w  = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (hs_aw) aw_left = 1'b0;
            if (hs_w) beat++;
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("write_accepted", 32'(aw_left || beat < nbeats), 32'd0);
    endtask

    // Same-cycle AW+W with explicit cycle-by-cycle latency checks; optional
    // read of the target pixel during the COMMIT cycle (expects old data).
    task automatic lat_write(input logic [31:0] addr, input logic [31:0] data,
                             input bit do_rd, input logic [4:0] ridx, input logic [23:0] old);
        push_b(2'b00, 1'b0);
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
        s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
        @(negedge clk);
        chk("lat_both_ready", 32'({s_axi_awready, s_axi_wready}), 32'h3);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (do_rd) begin
            rd_en_i = 1'b1; rd_addr_i = ridx; rq.push_back(old);
        end
        @(negedge clk);
        chk("lat_commit_no_b", 32'(s_axi_bvalid), 32'd0);
        chk("commit_ready_low", 32'({s_axi_awready, s_axi_wready}), 32'h0);
        @(posedge clk); #1;
        rd_en_i = 1'b0;
        @(negedge clk);
        chk("lat_b_visible", 32'(s_axi_bvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_b();
        int n = 0;
        while (bq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_response_timeout", 32'(bq.size()), 32'd0);
    endtask

    task automatic rd(input logic [4:0] idx, input logic [23:0] exp);
        rd_en_i = 1'b1; rd_addr_i = idx; rq.push_back(exp);
        @(posedge clk); #1;
        rd_en_i = 1'b0; rd_addr_i = ~idx;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_hold", 32'(rd_data_o), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_wready", 32'(s_axi_wready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
        chk("rst_wr_cnt", wr_cnt_o, 32'd0);
        chk("rst_frame_done", 32'(frame_done_o), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("awready_after_reset", 32'(s_axi_awready), 32'd1);
        chk("wready_after_reset", 32'(s_axi_wready), 32'd1);
        @(posedge clk); #1;

        // Same-cycle AW/W to index 5.
        lat_write(32'h4000_0014, 32'h00AB_CDEF, 1'b0, 5'd0, 24'h0);
        wait_b();
        rd(5'd5, 24'hABCDEF);
        chk("wr_cnt_1", wr_cnt_o, 32'd1);

        // W three cycles ahead of AW, B stalled by bready low.
        s_axi_bready = 1'b0;
        axi_write(32'h4000_0000, 32'h0011_2233, 4'hF, 8'd0, 1, 3'd2, 3, 2'b00, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("stall_ready_low", 32'({s_axi_awready, s_axi_wready}), 32'h0);
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b1;
        wait_b();
        rd(5'd0, 24'h112233);
        chk("wr_cnt_2", wr_cnt_o, 32'd2);

        // Illegal writes: out of range, misaligned, below base, wrong size, burst.
        axi_write(32'h4000_0080, 32'h00DE_AD01, 4'hF, 8'd0, 1, 3'd2, 0, 2'b10, 1'b0);
        wait_b();
        axi_write(32'h4000_0002, 32'h00DE_AD02, 4'hF, 8'd0, 1, 3'd2, 0, 2'b10, 1'b0);
        wait_b();
        axi_write(32'h3FFF_FFFC, 32'h00DE_AD03, 4'hF, 8'd0, 1, 3'd2, 0, 2'b10, 1'b0);
        wait_b();
        axi_write(32'h4000_0014, 32'h00DE_AD04, 4'hF, 8'd0, 1, 3'd1, 0, 2'b10, 1'b0);
        wait_b();
        axi_write(32'h4000_0000, 32'h0055_5555, 4'hF, 8'd3, 4, 3'd2, 0, 2'b10, 1'b0);
        wait_b();
        rd(5'd0, 24'h112233);
        rd(5'd5, 24'hABCDEF);
        chk("wr_cnt_after_slverr", wr_cnt_o, 32'd2);

        // Last pixel of the frame.
        axi_write(32'h4000_007C, 32'h00C0_FFEE, 4'hF, 8'd0, 1, 3'd2, 0, 2'b00, 1'b1);
        wait_b();
        rd(5'd31, 24'hC0FFEE);
        chk("wr_cnt_3", wr_cnt_o, 32'd3);

        // Byte strobes on index 1.
        axi_write(32'h4000_0004, 32'h0012_3456, 4'hF, 8'd0, 1, 3'd2, 0, 2'b00, 1'b0);
        wait_b();
        rd(5'd1, 24'h123456);
        axi_write(32'h4000_0004, 32'h00FF_FFFF, 4'b0010, 8'd0, 1, 3'd2, 0, 2'b00, 1'b0);
        wait_b();
`ifdef AXI_FB_WSTRB_EN
        rd(5'd1, 24'h12FF56);
`else
        rd(5'd1, 24'hFFFFFF);
`endif
        axi_write(32'h4000_0004, 32'h0000_0000, 4'b1000, 8'd0, 1, 3'd2, 0, 2'b00, 1'b0);
        wait_b();
`ifdef AXI_FB_WSTRB_EN
        rd(5'd1, 24'h12FF56);
`else
        rd(5'd1, 24'h000000);
`endif
        chk("wr_cnt_6", wr_cnt_o, 32'd6);

        // Read of index 5 in the same cycle as its write commits returns old data.
        lat_write(32'h4000_0014, 32'h0013_5790, 1'b1, 5'd5, 24'hABCDEF);
        wait_b();
        rd(5'd5, 24'h135790);
        chk("wr_cnt_7", wr_cnt_o, 32'd7);

        // Reset during COMMIT drops the write.
        axi_write(32'h4000_0008, 32'h0001_0203, 4'hF, 8'd0, 1, 3'd2, 0, 2'b00, 1'b0);
        wait_b();
        chk("wr_cnt_8", wr_cnt_o, 32'd8);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h4000_0008; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd2; s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0077_7777;
        s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("commit_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("commit_rst_wr_cnt", wr_cnt_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("commit_rst_awready", 32'(s_axi_awready), 32'd1);
        chk("commit_rst_wready", 32'(s_axi_wready), 32'd1);
        chk("commit_rst_no_b", 32'(s_axi_bvalid), 32'd0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rd(5'd2, 24'h010203);
        chk("wr_cnt_after_rst", wr_cnt_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
